// File: rtl/fetch_ctrl_if.sv
// Memory read bus between the fetch controller and instruction memory.
interface fetch_ctrl_if #(
    parameter int unsigned ADDR_W = 16,
    parameter int unsigned DATA_W = 16
);
    logic [ADDR_W-1:0] mem_addr;
    logic              mem_en;
    logic              mem_rd;
    logic              mfc;
    logic [DATA_W-1:0] mem_rdata;

    modport master (output mem_addr, mem_en, mem_rd, input mfc, mem_rdata);
    modport slave  (input mem_addr, mem_en, mem_rd, output mfc, mem_rdata);
endinterface

// File: rtl/fetch_ctrl.sv
// Multi-word instruction fetch controller with mem_en/mfc handshake,
// bounded memory-wait timeout and next-PC output.
module fetch_ctrl #(
    parameter int unsigned ADDR_W  = 16,
    parameter int unsigned DATA_W  = 16,
    parameter int unsigned WORDS   = 2,
    parameter int unsigned TIMEOUT = 15
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    start,
    input  logic [ADDR_W-1:0]       pc_in,
    fetch_ctrl_if.master            mem,
    output logic [WORDS*DATA_W-1:0] ir_out,
    output logic                    ir_valid,
    output logic [ADDR_W-1:0]       pc_next,
    output logic                    pc_load,
    output logic                    busy,
    output logic                    err
);
    localparam int unsigned CNT_W    = (WORDS > 1) ? $clog2(WORDS) : 1;
    localparam int unsigned TMR_W    = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
    localparam int unsigned TMR_LAST = (TIMEOUT == 0) ? 0 : TIMEOUT - 1;

    typedef enum logic [2:0] {
        S_IDLE, S_ADDR, S_REQ, S_WAIT, S_CAPT, S_DONE, S_ERR
    } state_t;

    state_t                          state, state_nx;
    logic [CNT_W-1:0]                word_cnt;
    logic [TMR_W-1:0]                timer;
    logic [ADDR_W-1:0]               addr_q;
    logic                            en_q;
    logic                            rd_q;
    logic [WORDS-1:0][DATA_W-1:0]    ir_q;
    logic                            last_word;
    logic [CNT_W-1:0]                wsel;

    assign last_word    = (word_cnt == CNT_W'(WORDS - 1));
    // First-fetched word lands in the most significant slot.
    assign wsel         = CNT_W'(WORDS - 1) - word_cnt;
    assign ir_out       = ir_q;
    assign mem.mem_addr = addr_q;
    assign mem.mem_en   = en_q;
    assign mem.mem_rd   = rd_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= S_IDLE;
        else       state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            S_IDLE: if (start) state_nx = S_ADDR;
            S_ADDR: state_nx = S_REQ;
            S_REQ:  state_nx = S_WAIT;
            S_WAIT: begin
                if (mem.mfc)
                    state_nx = S_CAPT;
                else if ((TIMEOUT != 0) && (timer == TMR_W'(TMR_LAST)))
                    state_nx = S_ERR;
            end
            S_CAPT: state_nx = last_word ? S_DONE : S_REQ;
            S_DONE: state_nx = S_IDLE;
            S_ERR:  state_nx = S_IDLE;
            default: state_nx = S_IDLE;
        endcase
    end

    // Datapath; strobes are registered from the next state so they track the state exactly.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            word_cnt <= '0;
            timer    <= '0;
            addr_q   <= '0;
            ir_q     <= '0;
            pc_next  <= '0;
            err      <= 1'b0;
            en_q     <= 1'b0;
            rd_q     <= 1'b0;
            ir_valid <= 1'b0;
            pc_load  <= 1'b0;
            busy     <= 1'b0;
        end else begin
            en_q     <= (state_nx == S_REQ);
            rd_q     <= (state_nx == S_REQ);
            ir_valid <= (state_nx == S_DONE);
            pc_load  <= (state_nx == S_DONE);
            busy     <= (state_nx != S_IDLE);
            if (state_nx == S_ERR) err <= 1'b1;
            case (state)
                S_IDLE: begin
                    if (start) begin
                        addr_q   <= pc_in;
                        pc_next  <= pc_in + ADDR_W'(WORDS);
                        word_cnt <= '0;
                        ir_q     <= '0;
                        err      <= 1'b0;
                    end
                end
                S_REQ: timer <= '0;
                S_WAIT: begin
                    if (mem.mfc) ir_q[wsel] <= mem.mem_rdata;
                    else         timer      <= timer + TMR_W'(1);
                end
                S_CAPT: begin
                    if (!last_word) begin
                        word_cnt <= word_cnt + CNT_W'(1);
                        addr_q   <= addr_q + ADDR_W'(1);
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_fetch_ctrl.sv
// Directed bench for fetch_ctrl: per-cycle timeline model plus literal expectations.
module tb_fetch_ctrl;
    localparam int unsigned ADDR_W  = 16;
    localparam int unsigned DATA_W  = 16;
    localparam int unsigned WORDS   = 2;
    localparam int unsigned TIMEOUT = 15;
    localparam int unsigned IRW     = WORDS * DATA_W;
    localparam int          MAXC    = 64;

    logic              clk = 1'b0;
    logic              reset;
    logic              start;
    logic [ADDR_W-1:0] pc_in;
    logic [IRW-1:0]    ir_out;
    logic              ir_valid;
    logic [ADDR_W-1:0] pc_next;
    logic              pc_load;
    logic              busy;
    logic              err;

    fetch_ctrl_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

    fetch_ctrl #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .WORDS(WORDS), .TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .reset(reset), .start(start), .pc_in(pc_in), .mem(bus.master),
        .ir_out(ir_out), .ir_valid(ir_valid), .pc_next(pc_next), .pc_load(pc_load),
        .busy(busy), .err(err)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Expected timeline: index = cycle number after the start-accept edge.
    logic              e_en[MAXC], e_busy[MAXC], e_valid[MAXC], e_err[MAXC];
    logic [ADDR_W-1:0] e_addr[MAXC];
    logic [IRW-1:0]    e_ir[MAXC];
    logic [ADDR_W-1:0] e_pcn;
    logic              d_mfc[MAXC], d_start[MAXC];
    logic [DATA_W-1:0] d_data[MAXC];
    int                n_cyc;
    int                cur;
    bit                chk_on = 1'b0;

    // Observations gathered by the compare process.
    int                valid_cnt, valid_cyc, en_cnt;
    logic [ADDR_W-1:0] en_addr[4];
    logic [ADDR_W-1:0] pcn_v;
    logic [IRW-1:0]    ir_v;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s cyc=%0d actual=%0h expected=%0h", name, cur, act, exp);
        end
    endtask

    task automatic put(input int t, input logic en, input logic bz, input logic vl, input logic er,
                       input logic [ADDR_W-1:0] a, input logic [IRW-1:0] ir);
        e_en[t] = en; e_busy[t] = bz; e_valid[t] = vl; e_err[t] = er; e_addr[t] = a; e_ir[t] = ir;
    endtask

    // Build the timeline of one fetch; a delay >= TIMEOUT means mfc never comes.
    task automatic plan(input logic [ADDR_W-1:0] pc, input logic [DATA_W-1:0] w0,
                        input logic [DATA_W-1:0] w1, input int d0, input int d1);
        logic [WORDS-1:0][DATA_W-1:0] ir;
        logic [DATA_W-1:0]            wd[WORDS];
        logic [ADDR_W-1:0]            a;
        int                           dl[WORDS];
        int                           t;
        wd[0] = w0; wd[1] = w1; dl[0] = d0; dl[1] = d1;
        for (int i = 0; i < MAXC; i++) begin
            d_mfc[i] = 1'b0; d_start[i] = 1'b0; d_data[i] = DATA_W'($urandom);
        end
        ir = '0; a = pc; t = 1;
        e_pcn = pc + ADDR_W'(WORDS);
        put(t, 0, 1, 0, 0, a, ir);
        for (int k = 0; k < WORDS; k++) begin
            t++; put(t, 1, 1, 0, 0, a, ir);
            if (dl[k] >= int'(TIMEOUT)) begin
                for (int j = 0; j < int'(TIMEOUT); j++) begin t++; put(t, 0, 1, 0, 0, a, ir); end
                t++; put(t, 0, 1, 0, 1, a, ir);
                t++; put(t, 0, 0, 0, 1, a, ir);
                n_cyc = t;
                return;
            end
            for (int j = 0; j <= dl[k]; j++) begin
                t++; put(t, 0, 1, 0, 0, a, ir);
                if (j == dl[k]) begin d_mfc[t] = 1'b1; d_data[t] = wd[k]; end
            end
            ir[WORDS-1-k] = wd[k];
            t++; put(t, 0, 1, 0, 0, a, ir);
            if (k < WORDS - 1) a = a + ADDR_W'(1);
        end
        t++; put(t, 0, 1, 1, 0, a, ir);
        t++; put(t, 0, 0, 0, 0, a, ir);
        n_cyc = t;
    endtask

    task automatic clear_obs();
        valid_cnt = 0; valid_cyc = -1; en_cnt = 0; pcn_v = '0; ir_v = '0;
        for (int i = 0; i < 4; i++) en_addr[i] = '0;
    endtask

    // Launch the planned fetch; stop_at > 0 leaves it mid-flight after that cycle.
    task automatic run(input logic [ADDR_W-1:0] pc, input int stop_at);
        clear_obs();
        pc_in = pc; start = 1'b1;
        @(posedge clk); #1;
        pc_in = ADDR_W'($urandom);
        cur = 1; chk_on = 1'b1;
        start = d_start[1]; bus.mfc = d_mfc[1]; bus.mem_rdata = d_data[1];
        while (cur < n_cyc && cur != stop_at) begin
            @(posedge clk); #1;
            cur++;
            start = d_start[cur]; bus.mfc = d_mfc[cur]; bus.mem_rdata = d_data[cur];
        end
        @(negedge clk); #1;
        chk_on = 1'b0; start = 1'b0; bus.mfc = 1'b0;
    endtask

    always @(negedge clk) begin
        if (ir_valid) begin valid_cnt++; valid_cyc = cur; pcn_v = pc_next; ir_v = ir_out; end
        if (bus.mem_en) begin
            if (en_cnt < 4) en_addr[en_cnt] = bus.mem_addr;
            en_cnt++;
        end
        if (chk_on) begin
            chk("mem_en",   64'(bus.mem_en), 64'(e_en[cur]));
            chk("mem_rd",   64'(bus.mem_rd), 64'(e_en[cur]));
            chk("busy",     64'(busy),       64'(e_busy[cur]));
            chk("ir_valid", 64'(ir_valid),   64'(e_valid[cur]));
            chk("pc_load",  64'(pc_load),    64'(e_valid[cur]));
            chk("err",      64'(err),        64'(e_err[cur]));
            chk("mem_addr", 64'(bus.mem_addr), 64'(e_addr[cur]));
            chk("ir_out",   64'(ir_out),     64'(e_ir[cur]));
            if (e_valid[cur]) chk("pc_next", 64'(pc_next), 64'(e_pcn));
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog time limit");
        $fatal(1);
    end

    initial begin
        reset = 1'b1; start = 1'b0; pc_in = '0; bus.mfc = 1'b0; bus.mem_rdata = '0; cur = 0;
        repeat (2) @(negedge clk);
        chk("rst_busy", 64'(busy), 0);
        chk("rst_en",   64'(bus.mem_en), 0);
        chk("rst_ir",   64'(ir_out), 0);
        chk("rst_pcn",  64'(pc_next), 0);
        chk("rst_err",  64'(err), 0);
        chk("rst_addr", 64'(bus.mem_addr), 0);
        reset = 1'b0;
        @(negedge clk); #1;

        // Single fetch, immediate memory
        plan(16'h0010, 16'hAAAA, 16'h5555, 0, 0);
        run(16'h0010, 0);
        chk("t1_valid_cyc", 64'(valid_cyc), 8);
        chk("t1_valid_cnt", 64'(valid_cnt), 1);
        chk("t1_en_cnt",    64'(en_cnt), 2);
        chk("t1_addr0",     64'(en_addr[0]), 64'h0010);
        chk("t1_addr1",     64'(en_addr[1]), 64'h0011);
        chk("t1_ir",        64'(ir_v), 64'hAAAA5555);
        chk("t1_pcn",       64'(pcn_v), 64'h0012);

        // Slow memory on word 0
        plan(16'h0040, 16'h1357, 16'h2468, 5, 0);
        run(16'h0040, 0);
        chk("slow_valid_cyc", 64'(valid_cyc), 13);
        chk("slow_err",       64'(err), 0);
        chk("slow_ir",        64'(ir_v), 64'h13572468);

        // Timeout: mfc never arrives
        plan(16'h0080, 16'h0, 16'h0, 99, 0);
        run(16'h0080, 0);
        chk("to_valid_cnt", 64'(valid_cnt), 0);
        chk("to_en_cnt",    64'(en_cnt), 1);
        repeat (3) @(negedge clk);
        chk("to_err_sticky", 64'(err), 1);
        chk("to_busy",       64'(busy), 0);
        #1;

        // Wrap; also clears err on accept
        plan(16'hFFFF, 16'h0F0F, 16'hF0F0, 0, 1);
        run(16'hFFFF, 0);
        chk("wrap_addr1", 64'(en_addr[1]), 64'h0000);
        chk("wrap_pcn",   64'(pcn_v), 64'h0001);
        chk("wrap_err",   64'(err), 0);

        // Stray start during WAIT, stray mfc in REQ/CAPT
        plan(16'h0300, 16'h1111, 16'h2222, 2, 0);
        d_mfc[2] = 1'b1; d_start[3] = 1'b1; d_mfc[6] = 1'b1; d_mfc[7] = 1'b1;
        run(16'h0300, 0);
        chk("stray_valid_cnt", 64'(valid_cnt), 1);
        chk("stray_valid_cyc", 64'(valid_cyc), 10);
        chk("stray_ir",        64'(ir_v), 64'h11112222);

        // Reset during second-word WAIT
        plan(16'h0100, 16'h1234, 16'hBEEF, 0, 3);
        run(16'h0100, 7);
        reset = 1'b1;
        #1;
        chk("mrst_busy", 64'(busy), 0);
        chk("mrst_en",   64'(bus.mem_en), 0);
        chk("mrst_ir",   64'(ir_out), 0);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk); #1;
        chk("mrst_valid_cnt", 64'(valid_cnt), 0);

        plan(16'h0200, 16'hCAFE, 16'hF00D, 0, 0);
        run(16'h0200, 0);
        chk("post_ir",  64'(ir_v), 64'hCAFEF00D);
        chk("post_pcn", 64'(pcn_v), 64'h0202);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/fetch_ctrl.md
Name: fetch_ctrl

Overview:
Parametrised instruction-fetch controller for the simple CPU. On `start` it latches the PC and reads `WORDS` consecutive memory words using an `mem_en`/`mfc` handshake. It assembles the words into a wide instruction register and pulses `ir_valid`, presenting the incremented PC. It adds what the single-word fetch FSM lacks: multi-word instructions, a bounded memory-wait timeout with an error flag, and a next-PC output.

Parameters:
ADDR_W, 16, width of PC and memory address
DATA_W, 16, memory word width
WORDS, 2, memory words per instruction (>=1)
TIMEOUT, 15, max WAIT cycles with `mfc` low before error; 0 disables the timeout

Ports:
clk  in  1  clock, rising edge
reset  in  1  asynchronous, active-high; all state and outputs cleared
start  in  1  fetch request; sampled only in IDLE
pc_in  in  ADDR_W  PC value, latched when `start` is accepted
mfc  in  1  memory function complete, active-high; sampled only in WAIT
mem_rdata  in  DATA_W  read data, valid when `mfc`=1
mem_addr  out  ADDR_W  registered read address
mem_en  out  1  memory enable, REQ state only
mem_rd  out  1  read strobe (1=read), REQ state only
ir_out  out  WORDS*DATA_W  assembled instruction; holds until the next accepted start or reset
ir_valid  out  1  one-cycle pulse, DONE state
pc_next  out  ADDR_W  pc_in + WORDS mod 2^ADDR_W; valid while `pc_load`=1
pc_load  out  1  one-cycle pulse, DONE state, coincident with `ir_valid`
busy  out  1  high in every state except IDLE
err  out  1  sticky timeout flag; set on entry to ERR, cleared when the next start is accepted

Behaviour:
- Reset (async): state=IDLE, `word_cnt`=0, `timer`=0, `mem_addr`=0, `ir_out`=0, `pc_next`=0, `err`=0, all strobes 0.
- Control outputs are Moore, decoded from state only; no combinational path from inputs to outputs.
- IDLE: if `start`=1 then latch `mem_addr`<=`pc_in`, `pc_next`<=`pc_in`+WORDS, `word_cnt`<=0, `ir_out`<=0, `err`<=0, and go to ADDR; else stay.
- ADDR: 1 cycle, address settle; go to REQ.
- REQ: `mem_en`=1, `mem_rd`=1 for exactly one cycle; `timer`<=0; go to WAIT. `mfc` is ignored in this state.
- WAIT: if `mfc`=1, write `mem_rdata` into IR word `word_cnt` and go to CAPT.
  - Else, if TIMEOUT!=0 and `timer`==TIMEOUT-1, go to ERR.
  - Else `timer`++ and stay.
- CAPT: if `word_cnt`==WORDS-1, go to DONE. Else `word_cnt`++, `mem_addr`<=`mem_addr`+1 (wraps mod 2^ADDR_W), and go to REQ (ADDR is not revisited).
- DONE: `ir_valid`=1, `pc_load`=1 for one cycle; go to IDLE.
- ERR: 1 cycle, `err`<=1; go to IDLE. `ir_valid` and `pc_load` are not asserted; `ir_out` keeps its partial contents.
- Word order: word k occupies `ir_out`[(WORDS-k)*DATA_W-1 -: DATA_W], so the first-fetched word is the most significant.
- Latency: counting the ADDR cycle as cycle 1 after the start-accept edge, `ir_valid` falls in cycle 2+3*WORDS plus the total extra WAIT cycles. For WORDS=2 with immediate `mfc`, this is cycle 8.
- Back-to-back: `start` held high in the cycle after DONE (IDLE) launches the next fetch immediately.
- Boundaries:
  - `start` while `busy`: ignored.
  - `mfc` high outside WAIT: ignored.
  - Reset mid-fetch: immediate return to IDLE, outputs cleared, no `ir_valid`.
  - WORDS=1: CAPT goes directly to DONE.

Test Plan:
- Single fetch, WORDS=2, `pc_in`=0x0010, `mfc` high in the first WAIT cycle each word, `mem_rdata` 0xAAAA then 0x5555 -> `mem_addr` 0x0010 then 0x0011; `ir_out`=0xAAAA5555; `ir_valid`/`pc_load` in cycle 8; `pc_next`=0x0012; `mem_en` high exactly 2 cycles.
- Wrap: `pc_in`=0xFFFF, WORDS=2 -> second `mem_addr`=0x0000; `pc_next`=0x0001.
- Slow memory: `mfc` delayed 5 WAIT cycles on word 0 -> `ir_valid` in cycle 13; `err`=0.
- Timeout: TIMEOUT=15, `mfc` never asserted -> ERR after 15 WAIT cycles; `err`=1 sticky, no `ir_valid`, `busy`=0 in the next cycle; next accepted start clears `err`.
- `start` pulsed during WAIT and `mfc` pulsed during REQ -> both ignored; the fetch completes normally with a single `ir_valid`.
- Reset asserted during the second-word WAIT -> same cycle: `busy`=0, `mem_en`=0, `ir_out`=0; no `ir_valid`; the subsequent start fetches correctly.
